imem_server: RTL and testbench

IMEM_SERVER -- requirements
Module: imem_server

---
 rtl/imem_server_pkg.sv | 23 ++
 rtl/imem_server_if.sv | 23 ++
 rtl/imem_word_packer.sv | 36 +++
 rtl/imem_server.sv | 125 ++++++++++++
 tb/tb_imem_server.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/imem_server_pkg.sv
// Shared types and constants for the instruction-memory server.
// Also carries the built-in boot image used when IMEM_BOOT_LOADER_EN is not defined.
package imem_server_pkg;

  localparam logic [31:0] IMEM_NOP_DEFAULT = 32'h0000_0013;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } loader_state_e;

  // Elaboration-time boot image; words past the listed program read as nop.
  function automatic logic [31:0] boot_word(input logic [31:0] idx, input logic [31:0] nop);
    case (idx)
      32'd0:   boot_word = 32'h0010_0093;
      32'd1:   boot_word = 32'h0020_8113;
      32'd2:   boot_word = 32'h0020_81b3;
      32'd3:   boot_word = 32'h0000_006f;
      default: boot_word = nop;
    endcase
  endfunction

endpackage

// File: rtl/imem_server_if.sv
// Fetch and boot-load signal bundle between the core/loader side (master)
// and the instruction-memory server (slave).
interface imem_server_if;
  logic [31:0] imem_addr_in;
  logic [31:0] imem_data_out;
  logic        imem_ready_out;
  logic        imem_fault_out;
  logic [7:0]  load_data_in;
  logic        load_valid_in;
  logic        load_last_in;
  logic        load_ready_out;
  logic        load_error_out;

  modport master (
    output imem_addr_in, load_data_in, load_valid_in, load_last_in,
    input  imem_data_out, imem_ready_out, imem_fault_out, load_ready_out, load_error_out
  );

  modport slave (
    input  imem_addr_in, load_data_in, load_valid_in, load_last_in,
    output imem_data_out, imem_ready_out, imem_fault_out, load_ready_out, load_error_out
  );
endinterface

// File: rtl/imem_word_packer.sv
// Assembles little-endian boot bytes into 32-bit words. word/word_vld are
// combinational so the completing byte is written in the same cycle it arrives.
module imem_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  data,
  input  logic        vld,
  input  logic        last,
  output logic [31:0] word,
  output logic        word_vld
);

  logic [1:0]  lane;
  logic [31:0] pack_q;

  // Lanes at or above the current one are always zero in pack_q, so OR-ing
  // in the new byte leaves unfilled upper lanes cleared on a short last word.
  assign word     = pack_q | ({24'd0, data} << {lane, 3'b000});
  assign word_vld = vld && ((lane == 2'd3) || last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane   <= 2'd0;
      pack_q <= 32'd0;
    end else if (vld) begin
      if (word_vld) begin
        lane   <= 2'd0;
        pack_q <= 32'd0;
      end else begin
        lane   <= lane + 2'd1;
        pack_q <= word;
      end
    end
  end

endmodule

// File: rtl/imem_server.sv
// Instruction memory with zero-latency fetch and an optional byte-stream boot
// loader (macro IMEM_BOOT_LOADER_EN); without it the array is a fixed boot image.
module imem_server
  import imem_server_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD   = IMEM_NOP_DEFAULT
) (
  input logic          clock_in,
  input logic          reset_in,
  imem_server_if.slave bus
);

  logic [31:0]           offset;
  logic [DEPTH_LOG2-1:0] index;
  logic                  out_of_range;
  logic                  misaligned;
  logic                  ready_q;
  logic                  fault;
  logic [31:0]           array_word;
  logic                  accept;
  logic [31:0]           packed_word;
  logic                  packed_vld;

  assign offset       = bus.imem_addr_in - BASE_ADDR;
  assign index        = offset[DEPTH_LOG2+1:2];
  assign out_of_range = |offset[31:DEPTH_LOG2+2];
  assign misaligned   = |bus.imem_addr_in[1:0];

  // Faults are only reported once the image is servable.
  assign fault              = ready_q && (misaligned || out_of_range);
  assign bus.imem_fault_out = fault;
  assign bus.imem_ready_out = ready_q;
  assign bus.imem_data_out  = (ready_q && !fault) ? array_word : NOP_WORD;

  imem_word_packer u_packer (
    .clk      (clock_in),
    .rst_n    (reset_in),
    .data     (bus.load_data_in),
    .vld      (accept),
    .last     (bus.load_last_in),
    .word     (packed_word),
    .word_vld (packed_vld)
  );

`ifdef IMEM_BOOT_LOADER_EN

  loader_state_e         state;
  logic [DEPTH_LOG2-1:0] word_ptr;
  logic                  load_ready_q;
  logic                  load_error_q;
  logic [31:0]           mem [0:(1 << DEPTH_LOG2)-1];

  assign accept             = (state == LOAD) && bus.load_valid_in;
  assign bus.load_ready_out = load_ready_q;
  assign bus.load_error_out = load_error_q;
  assign array_word         = mem[index];

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state        <= LOAD;
      word_ptr     <= '0;
      load_ready_q <= 1'b1;
      ready_q      <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (packed_vld) begin
            if (bus.load_last_in) begin
              state        <= RUN;
              load_ready_q <= 1'b0;
              ready_q      <= 1'b1;
            end else if (&word_ptr) begin
              // Array full with more image to come: stop here rather than wrap.
              state        <= RUN;
              load_ready_q <= 1'b0;
              ready_q      <= 1'b1;
              load_error_q <= 1'b1;
            end else begin
              word_ptr <= word_ptr + DEPTH_LOG2'(1);
            end
          end
        end
        RUN: begin
          load_ready_q <= 1'b0;
          ready_q      <= 1'b1;
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Array is deliberately outside reset so a reload only overwrites what it reaches.
  always_ff @(posedge clock_in) begin
    if (packed_vld) begin
      mem[word_ptr] <= packed_word;
    end
  end

  logic unused_fetch;
  assign unused_fetch = ^offset[1:0];

`else

  assign accept             = 1'b0;
  assign bus.load_ready_out = 1'b0;
  assign bus.load_error_out = 1'b0;
  assign array_word         = boot_word(32'(index), NOP_WORD);

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
    end
  end

  logic unused_load;
  assign unused_load = ^{offset[1:0], bus.load_valid_in, packed_word, packed_vld};

`endif

endmodule

// File: tb/tb_imem_server.sv
// Directed bench for imem_server; exercises the boot loader when
// IMEM_BOOT_LOADER_EN is defined, otherwise the fixed boot image.
module tb_imem_server;

  logic clock_in;
  logic reset_in;
  int   n_total;
  int   n_bad;

  imem_server_if bus ();

  imem_server #(
    .DEPTH_LOG2 (10),
    .BASE_ADDR  (32'h0000_0000),
    .NOP_WORD   (32'h0000_0013)
  ) dut (
    .clock_in (clock_in),
    .reset_in (reset_in),
    .bus      (bus)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic fetch_chk(input string tag, input logic [31:0] addr,
                           input logic [31:0] exp_data, input logic exp_fault);
    bus.imem_addr_in = addr;
    #1;
    chk({tag, "_data"}, bus.imem_data_out, exp_data);
    chk({tag, "_fault"}, 32'(bus.imem_fault_out), 32'(exp_fault));
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    bus.load_data_in  = b;
    bus.load_valid_in = 1'b1;
    bus.load_last_in  = last;
    @(posedge clock_in);
    #1;
    bus.load_valid_in = 1'b0;
    bus.load_last_in  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock_in);
    reset_in = 1'b0;
    @(negedge clock_in);
    reset_in = 1'b1;
    @(posedge clock_in);
    #1;
  endtask

  initial begin
    #300_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_total           = 0;
    n_bad             = 0;
    reset_in          = 1'b1;
    bus.imem_addr_in  = 32'd0;
    bus.load_data_in  = 8'd0;
    bus.load_valid_in = 1'b0;
    bus.load_last_in  = 1'b0;
    #2;
    reset_in = 1'b0;
    #20;
    chk("rst_imem_ready", 32'(bus.imem_ready_out), 32'd0);
    chk("rst_load_error", 32'(bus.load_error_out), 32'd0);
    fetch_chk("rst_fetch0", 32'h0, 32'h0000_0013, 1'b0);
    fetch_chk("rst_fetch_mis", 32'h6, 32'h0000_0013, 1'b0);

`ifdef IMEM_BOOT_LOADER_EN
    chk("rst_load_ready", 32'(bus.load_ready_out), 32'd1);
    @(negedge clock_in);
    reset_in = 1'b1;
    @(posedge clock_in);
    #1;

    // Two-word image; the final byte's cycle must still fetch nop.
    send_byte(8'h13, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h93, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h10, 1'b0);
    bus.load_data_in  = 8'h00;
    bus.load_valid_in = 1'b1;
    bus.load_last_in  = 1'b1;
    bus.imem_addr_in  = 32'h4;
    #1;
    chk("final_cycle_data", bus.imem_data_out, 32'h0000_0013);
    chk("final_cycle_ready", 32'(bus.imem_ready_out), 32'd0);
    @(posedge clock_in);
    #1;
    bus.load_valid_in = 1'b0;
    bus.load_last_in  = 1'b0;
    chk("img2_ready", 32'(bus.imem_ready_out), 32'd1);
    chk("img2_load_ready", 32'(bus.load_ready_out), 32'd0);
    fetch_chk("img2_w0", 32'h0, 32'h0000_0013, 1'b0);
    fetch_chk("img2_w1", 32'h4, 32'h0010_0093, 1'b0);
    fetch_chk("run_misaligned", 32'h6, 32'h0000_0013, 1'b1);
    fetch_chk("run_range", 32'h1000, 32'h0000_0013, 1'b1);
    bus.imem_addr_in = 32'hFFC;
    #1;
    chk("run_top_fault", 32'(bus.imem_fault_out), 32'd0);

    // Load inputs must be ignored once running.
    send_byte(8'h77, 1'b1);
    send_byte(8'h77, 1'b1);
    fetch_chk("run_ignore_w0", 32'h0, 32'h0000_0013, 1'b0);
    chk("run_ignore_ready", 32'(bus.imem_ready_out), 32'd1);

    // Reset mid-load restarts at word 0 and leaves untouched words intact.
    do_reset();
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0); send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0); send_byte(8'h55, 1'b0); send_byte(8'h66, 1'b0);
    chk("midload_ready", 32'(bus.imem_ready_out), 32'd0);
    do_reset();
    send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h03, 1'b0);
    chk("reload_ready_pre", 32'(bus.imem_ready_out), 32'd0);
    send_byte(8'h04, 1'b1);
    chk("reload_ready_post", 32'(bus.imem_ready_out), 32'd1);
    fetch_chk("reload_w0", 32'h0, 32'h0403_0201, 1'b0);
    fetch_chk("reload_w1_kept", 32'h4, 32'h0010_0093, 1'b0);

    // Partial final word: upper lanes zero.
    do_reset();
    send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0); send_byte(8'hCC, 1'b0);
    send_byte(8'hDD, 1'b0); send_byte(8'hEE, 1'b1);
    chk("part_ready", 32'(bus.imem_ready_out), 32'd1);
    fetch_chk("part_w0", 32'h0, 32'hDDCC_BBAA, 1'b0);
    fetch_chk("part_w1", 32'h4, 32'h0000_00EE, 1'b0);

    // Overflow: 4100 bytes, no last.
    do_reset();
    for (int i = 0; i < 4095; i++) send_byte(8'(i), 1'b0);
    chk("ovf_err_pre", 32'(bus.load_error_out), 32'd0);
    chk("ovf_lready_pre", 32'(bus.load_ready_out), 32'd1);
    send_byte(8'hFF, 1'b0);
    chk("ovf_err", 32'(bus.load_error_out), 32'd1);
    chk("ovf_lready", 32'(bus.load_ready_out), 32'd0);
    chk("ovf_ready", 32'(bus.imem_ready_out), 32'd1);
    for (int i = 0; i < 4; i++) send_byte(8'h5A, 1'b0);
    fetch_chk("ovf_w0", 32'h0, 32'h0302_0100, 1'b0);
    fetch_chk("ovf_wtop", 32'hFFC, 32'hFFFE_FDFC, 1'b0);
    chk("ovf_err_sticky", 32'(bus.load_error_out), 32'd1);
`else
    chk("rst_load_ready", 32'(bus.load_ready_out), 32'd0);
    @(negedge clock_in);
    reset_in = 1'b1;
    @(posedge clock_in);
    #1;
    chk("rom_ready", 32'(bus.imem_ready_out), 32'd1);
    fetch_chk("rom_w0", 32'h0, 32'h0010_0093, 1'b0);
    fetch_chk("rom_w1", 32'h4, 32'h0020_8113, 1'b0);
    fetch_chk("rom_w2", 32'h8, 32'h0020_81b3, 1'b0);
    fetch_chk("rom_w3", 32'hC, 32'h0000_006f, 1'b0);
    fetch_chk("rom_past_image", 32'h10, 32'h0000_0013, 1'b0);
    fetch_chk("rom_misaligned", 32'h2, 32'h0000_0013, 1'b1);
    fetch_chk("rom_range", 32'h1000, 32'h0000_0013, 1'b1);
    fetch_chk("rom_top", 32'hFFC, 32'h0000_0013, 1'b0);
    send_byte(8'hAB, 1'b1);
    chk("rom_load_ready", 32'(bus.load_ready_out), 32'd0);
    chk("rom_load_error", 32'(bus.load_error_out), 32'd0);
    fetch_chk("rom_w0_after_load", 32'h0, 32'h0010_0093, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
